// File: rtl/main_memory_arbiter_pkg.sv
// Shared definitions for the main memory arbiter and its backing array.
package main_memory_arbiter_pkg;

    localparam int unsigned DefaultLatency   = 10;
    localparam int unsigned DefaultLineWidth = 128;
    localparam int unsigned DefaultMemDepth  = 4096;

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } arb_state_e;

endpackage

// File: rtl/main_memory_array.sv
// Line-wide backing store: one synchronous write port, one combinational read port.
module main_memory_array #(
    parameter int unsigned LINE_WIDTH = 128,
    parameter int unsigned MEM_DEPTH  = 4096,
    localparam int unsigned IdxW      = $clog2(MEM_DEPTH)
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [IdxW-1:0]       wr_idx,
    input  logic [LINE_WIDTH-1:0] wr_data,
    input  logic [IdxW-1:0]       rd_idx,
    output logic [LINE_WIDTH-1:0] rd_data
);

    // Contents are deliberately not reset; they are preloaded externally.
    logic [LINE_WIDTH-1:0] mem [MEM_DEPTH];

    // Synchronous line write.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/main_memory_arbiter.sv
// Arbitrates line requests from several cache channels onto a single fixed-latency memory.
module main_memory_arbiter
    import main_memory_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = DefaultLineWidth,
    parameter int unsigned MEM_DEPTH  = DefaultMemDepth,
    parameter int unsigned LATENCY    = DefaultLatency,
    parameter int unsigned ARB_MODE   = 0
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ-1:0]                  req_we,
    input  logic [NUM_REQ-1:0][LINE_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [LINE_WIDTH-1:0]               rsp_data,
    output logic                                busy
);

    localparam int unsigned GntW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = $clog2(LATENCY + 1);
    localparam int unsigned OffW = $clog2(LINE_WIDTH / 8);
    localparam int unsigned IdxW = $clog2(MEM_DEPTH);

    typedef struct packed {
        logic            found;
        logic [GntW-1:0] idx;
    } arb_result_t;

    // Fixed priority: lowest index wins. Round-robin: search starts just after last grant.
    // Loops run from lowest to highest priority so the last hit is the winner.
    function automatic arb_result_t arbitrate(input logic [NUM_REQ-1:0] req,
                                              input logic [GntW-1:0]    last);
        arb_result_t res;
        int unsigned cand;
        res = '0;
        if (ARB_MODE == 0) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (req[i]) begin
                    res.found = 1'b1;
                    res.idx   = GntW'(i);
                end
            end
        end else begin
            for (int unsigned i = NUM_REQ; i >= 1; i--) begin
                cand = (32'(last) + i) % NUM_REQ;
                if (req[cand]) begin
                    res.found = 1'b1;
                    res.idx   = GntW'(cand);
                end
            end
        end
        return res;
    endfunction

    arb_state_e            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [GntW-1:0]       gnt_q, last_q;
    logic                  we_q;
    logic [IdxW-1:0]       idx_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic [LINE_WIDTH-1:0] rsp_data_q;
    logic [LINE_WIDTH-1:0] rd_data;
    arb_result_t           arb;
    logic                  gnt_live;
    logic                  rsp_fire;
    logic                  grant;

    // Only the line-index bits of the address matter; the rest alias.
    logic unused_addr;
    assign unused_addr = ^req_addr;

    assign arb      = arbitrate(req_valid, last_q);
    assign grant    = (state_q == StIdle) && arb.found;
    assign gnt_live = req_valid[gnt_q];
    assign rsp_fire = (state_q == StBusy) && gnt_live && (cnt_q == CntW'(LATENCY - 1));

    // Next-state: grant from idle, count latency in busy, leave on completion or flush.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (arb.found) begin
                    state_d = StBusy;
                    cnt_d   = '0;
                end
            end
            StBusy: begin
                if (!gnt_live || rsp_fire) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counter and captured transaction registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            gnt_q      <= '0;
            last_q     <= GntW'(NUM_REQ - 1);
            we_q       <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (grant) begin
                gnt_q   <= arb.idx;
                last_q  <= arb.idx;
                we_q    <= req_we[arb.idx];
                idx_q   <= req_addr[arb.idx][OffW +: IdxW];
                wdata_q <= req_wdata[arb.idx];
            end
            if (rsp_fire && !we_q) begin
                rsp_data_q <= rd_data;
            end
        end
    end

    // Outputs: a single-channel completion pulse; read data shows in the pulse cycle.
    always_comb begin
        rsp_valid = '0;
        if (rsp_fire) begin
            rsp_valid[gnt_q] = 1'b1;
        end
        rsp_data = (rsp_fire && !we_q) ? rd_data : rsp_data_q;
        busy     = (state_q == StBusy);
    end

    main_memory_array #(
        .LINE_WIDTH (LINE_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_array (
        .clock   (clock),
        .wr_en   (rsp_fire && we_q),
        .wr_idx  (idx_q),
        .wr_data (wdata_q),
        .rd_idx  (idx_q),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_main_memory_arbiter.sv
// Directed bench: fixed-priority instance for most scenarios, round-robin instance for alternation.
module tb_main_memory_arbiter;

    logic              clock;
    logic              reset;
    logic [1:0]        req_valid;
    logic [1:0][31:0]  req_addr;
    logic [1:0]        req_we;
    logic [1:0][127:0] req_wdata;
    logic [1:0]        rsp_valid;
    logic [127:0]      rsp_data;
    logic              busy;

    logic [1:0]        rr_valid;
    logic [1:0][31:0]  rr_addr;
    logic [1:0]        rr_we;
    logic [1:0][127:0] rr_wdata;
    logic [1:0]        rr_rsp_valid;
    logic [127:0]      rr_rsp_data;
    logic              rr_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int p0 = 0, p1 = 0, multi = 0;

    main_memory_arbiter #(.ARB_MODE(0)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    main_memory_arbiter #(.ARB_MODE(1)) dut_rr (
        .clock     (clock),
        .reset     (reset),
        .req_valid (rr_valid),
        .req_addr  (rr_addr),
        .req_we    (rr_we),
        .req_wdata (rr_wdata),
        .rsp_valid (rr_rsp_valid),
        .rsp_data  (rr_rsp_data),
        .busy      (rr_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulse bookkeeping for the fixed-priority instance, plus multi-hot detection on both.
    always @(negedge clock) begin
        if (rsp_valid[0]) p0++;
        if (rsp_valid[1]) p1++;
        if ($countones(rsp_valid) > 1 || $countones(rr_rsp_valid) > 1) multi++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // From the negedge of the grant cycle, find the first response (bounded).
    task automatic wait_rsp(input bit use_rr, output int cyc, output logic [1:0] vec,
                            output logic [127:0] data);
        bit done;
        done = 1'b0;
        cyc  = -1;
        vec  = '0;
        data = '0;
        for (int c = 1; c <= 40; c++) begin
            if (!done) begin
                @(negedge clock);
                if (use_rr ? (rr_rsp_valid != 0) : (rsp_valid != 0)) begin
                    cyc  = c;
                    vec  = use_rr ? rr_rsp_valid : rsp_valid;
                    data = use_rr ? rr_rsp_data : rsp_data;
                    done = 1'b1;
                end
            end
        end
    endtask

    int           cyc;
    logic [1:0]   vec;
    logic [127:0] data;
    int           p1_snap;

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_we    = '0;
        req_wdata = '0;
        rr_valid  = '0;
        rr_addr   = '0;
        rr_we     = '0;
        rr_wdata  = '0;
        dut.u_array.mem[1]    = 128'h11;
        dut.u_array.mem[2]    = 128'h22;
        dut.u_array.mem[4]    = {4{32'hA5A5A5A5}};
        dut.u_array.mem[8]    = 128'h0;
        dut_rr.u_array.mem[0] = 128'h0;

        #3 reset = 1'b0;
        #1;
        check("reset_rsp_valid", 128'(rsp_valid), 128'h0);
        check("reset_busy", 128'(busy), 128'h0);
        check("reset_rsp_data", rsp_data, 128'h0);
        next_cycle();
        reset = 1'b1;

        // Single read: ch1 reads 0x40 (line 4).
        next_cycle();
        req_valid = 2'b10;
        req_addr[1] = 32'h40;
        req_we[1] = 1'b0;
        @(negedge clock);
        check("read_busy_grant_cycle", 128'(busy), 128'h0);
        wait_rsp(1'b0, cyc, vec, data);
        check("read_latency", 128'(cyc), 128'd10);
        check("read_rsp_vec", 128'(vec), 128'b10);
        check("read_data", data, {4{32'hA5A5A5A5}});
        next_cycle();
        req_valid = 2'b00;
        @(negedge clock);
        check("read_pulse_one_cycle", 128'(rsp_valid), 128'h0);
        check("read_idle_after", 128'(busy), 128'h0);

        // Contention, fixed priority: ch0 first, ch1 re-granted the cycle after.
        next_cycle();
        req_valid = 2'b11;
        req_addr[0] = 32'h10;
        req_addr[1] = 32'h20;
        req_we = 2'b00;
        @(negedge clock);
        wait_rsp(1'b0, cyc, vec, data);
        check("cont_ch0_latency", 128'(cyc), 128'd10);
        check("cont_ch0_vec", 128'(vec), 128'b01);
        check("cont_ch0_data", data, 128'h11);
        next_cycle();
        req_valid = 2'b10;
        @(negedge clock);
        check("cont_ch1_grant_idle", 128'(busy), 128'h0);
        wait_rsp(1'b0, cyc, vec, data);
        check("cont_ch1_latency", 128'(cyc), 128'd10);
        check("cont_ch1_vec", 128'(vec), 128'b10);
        check("cont_ch1_data", data, 128'h22);
        next_cycle();
        req_valid = 2'b00;

        // Write 0xDEAD to 0x80, then read it back through an aliased address.
        next_cycle();
        req_valid = 2'b01;
        req_addr[0] = 32'h80;
        req_we[0] = 1'b1;
        req_wdata[0] = 128'hDEAD;
        @(negedge clock);
        wait_rsp(1'b0, cyc, vec, data);
        check("write_latency", 128'(cyc), 128'd10);
        check("write_vec", 128'(vec), 128'b01);
        check("write_rsp_data_held", data, 128'h22);
        next_cycle();
        req_valid = 2'b00;
        req_we = 2'b00;
        next_cycle();
        req_valid = 2'b10;
        req_addr[1] = 32'h80 + 32'(4096 * 16);
        @(negedge clock);
        wait_rsp(1'b0, cyc, vec, data);
        check("alias_read_vec", 128'(vec), 128'b10);
        check("alias_read_data", data, 128'hDEAD);
        next_cycle();
        req_valid = 2'b00;

        // Abort: ch1 write flushed at T+5, pending ch0 read granted at T+6.
        p1_snap = p1;
        next_cycle();
        req_valid = 2'b10;
        req_addr[1] = 32'h80;
        req_we[1] = 1'b1;
        req_wdata[1] = 128'hBEEF;
        req_addr[0] = 32'h80;
        req_we[0] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            req_valid = 2'b11;
        end
        next_cycle();
        req_valid = 2'b01;
        @(negedge clock);
        check("abort_busy_t5", 128'(busy), 128'h1);
        next_cycle();
        @(negedge clock);
        check("abort_idle_t6", 128'(busy), 128'h0);
        wait_rsp(1'b0, cyc, vec, data);
        check("abort_ch0_latency", 128'(cyc), 128'd10);
        check("abort_ch0_vec", 128'(vec), 128'b01);
        check("abort_no_write", data, 128'hDEAD);
        next_cycle();
        req_valid = 2'b00;
        req_we = 2'b00;
        check("abort_no_ch1_pulse", 128'(p1 - p1_snap), 128'h0);

        // Reset in the middle of a write: outputs clear at once, line keeps old data.
        next_cycle();
        req_valid = 2'b01;
        req_addr[0] = 32'h80;
        req_we[0] = 1'b1;
        req_wdata[0] = 128'h5555;
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
        end
        reset = 1'b0;
        #1;
        check("rst_mid_rsp_valid", 128'(rsp_valid), 128'h0);
        check("rst_mid_busy", 128'(busy), 128'h0);
        check("rst_mid_rsp_data", rsp_data, 128'h0);
        req_valid = 2'b00;
        req_we = 2'b00;
        next_cycle();
        reset = 1'b1;
        next_cycle();
        req_valid = 2'b10;
        req_addr[1] = 32'h80;
        @(negedge clock);
        wait_rsp(1'b0, cyc, vec, data);
        check("post_rst_latency", 128'(cyc), 128'd10);
        check("post_rst_vec", 128'(vec), 128'b10);
        check("post_rst_line_kept", data, 128'hDEAD);
        next_cycle();
        req_valid = 2'b00;

        // Round-robin with both channels requesting continuously.
        next_cycle();
        rr_valid = 2'b11;
        @(negedge clock);
        for (int k = 0; k < 4; k++) begin
            wait_rsp(1'b1, cyc, vec, data);
            check($sformatf("rr_latency_%0d", k), 128'(cyc), (k == 0) ? 128'd10 : 128'd11);
            check($sformatf("rr_vec_%0d", k), 128'(vec), (k % 2 == 0) ? 128'b01 : 128'b10);
        end
        next_cycle();
        rr_valid = 2'b00;
        next_cycle();
        check("no_multi_hot_rsp", 128'(multi), 128'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/main_memory_arbiter.md
MAIN_MEMORY_ARBITER -- requirements
Module: main_memory_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning): NUM_REQ, 2, requester channels (channel 0 = dcache, 1 = icache).
REQ-002 SHALL have: ADDR_WIDTH, 32, byte address width.
REQ-003 SHALL have: LINE_WIDTH, 128, line width in bits (power of two, >=32).
REQ-004 SHALL have: MEM_DEPTH, 4096, lines in the backing array (power of two).
REQ-005 SHALL have: LATENCY, 10, cycles from grant to response (>=1).
REQ-006 SHALL have: ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-007 SHALL have ports (name, direction, width, meaning): clock, in, 1, single clock; all logic on rising edge.
REQ-008 SHALL have: reset, in, 1, asynchronous, active-low reset.
REQ-009 SHALL have: req_valid, in, NUM_REQ, per-channel request, held until that channel's rsp_valid.
REQ-010 SHALL have: req_addr, in, NUM_REQ x ADDR_WIDTH, per-channel byte address.
REQ-011 SHALL have: req_we, in, NUM_REQ, 1 = line write, 0 = line read.
REQ-012 SHALL have: req_wdata, in, NUM_REQ x LINE_WIDTH, write line data.
REQ-013 SHALL have: rsp_valid, out, NUM_REQ, one-cycle completion pulse per channel (reads and writes).
REQ-014 SHALL have: rsp_data, out, LINE_WIDTH, read line, shared by all channels, qualified by rsp_valid.
REQ-015 SHALL have: busy, out, 1, high while a transaction is outstanding.

Function
REQ-016 SHALL implement FSM states IDLE and BUSY; reset state IDLE.
REQ-017 In IDLE with any req_valid set, SHALL grant one channel, capture its addr/we/wdata, clear the latency counter, and enter BUSY on the next edge.
REQ-018 In ARB_MODE 0, SHALL grant the lowest-indexed requesting channel.
REQ-019 In ARB_MODE 1, SHALL search from (last_grant+1) mod NUM_REQ upward with wrap; last_grant resets to NUM_REQ-1, so channel 0 wins first.
REQ-020 In BUSY, SHALL increment the counter each cycle; counter width is $clog2(LATENCY+1).
REQ-021 Grant in cycle T SHALL produce rsp_valid[grant] in cycle T+LATENCY, exactly one cycle wide, followed by IDLE.
REQ-022 On a read, rsp_data SHALL equal mem[line index] in the rsp_valid cycle; otherwise rsp_data holds its previous value.
REQ-023 On a write, the array SHALL be updated at the edge closing the rsp_valid cycle; rsp_data is unchanged.
REQ-024 Line index SHALL be req_addr[$clog2(LINE_WIDTH/8) +: $clog2(MEM_DEPTH)]; higher address bits are ignored (aliasing wraps).
REQ-025 Captured addr/we/wdata SHALL be used for the whole transaction; input changes during BUSY are ignored.
REQ-026 If the granted channel drops req_valid during BUSY (flush), SHALL abort: no rsp_valid, no array write, IDLE next cycle.
REQ-027 Requesters SHALL drop req_valid in the cycle after rsp_valid; the earliest re-grant is the cycle after rsp_valid, and a still-high req_valid starts a new transaction.
REQ-028 Non-granted requests SHALL wait with no response; no response pulse to more than one channel per cycle.
REQ-029 busy SHALL be high exactly in BUSY.

Reset
REQ-030 Asserting reset (low) SHALL asynchronously force IDLE, counter 0, rsp_valid 0, rsp_data 0, busy 0, last_grant NUM_REQ-1, and abort any transaction without a write.
REQ-031 Array contents SHALL NOT be reset; the bench preloads them.

Structure
REQ-032 LATENCY, LINE_WIDTH, MEM_DEPTH, and the FSM state enum SHALL be defined in the shared soc package; module parameters default to them.
REQ-033 The backing store SHALL be a sub-module main_memory_array (one read port, one write port, synchronous write, combinational read).
REQ-034 Arbitration SHALL be a function in this module, not a separate module.

Verification
REQ-035 Single read: ch1 reads 0x40, mem[4]=0xA5..A5, LATENCY=10 -> rsp_valid[1] only in cycle T+10, rsp_data=0xA5..A5.
REQ-036 Contention, ARB_MODE 0: ch0 and ch1 both request in cycle T -> ch0 responds at T+10, ch1 is granted at T+11 and responds at T+21.
REQ-037 Round-robin, ARB_MODE 1: both channels request continuously -> grants alternate 0,1,0,1; no channel is granted twice in a row.
REQ-038 Write then read: ch0 writes 0xDEAD to 0x80, then ch1 reads 0x80 -> ch1 rsp_data=0xDEAD; address 0x80+MEM_DEPTH*16 aliases to the same line.
REQ-039 Abort: ch1 drops req_valid at T+5 -> no rsp_valid; busy low at T+6; pending ch0 is granted at T+6.
REQ-040 Reset mid-write: reset low at T+4 -> outputs zero at once, array line unchanged, and after release the first request is served normally.
